// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: unpacks a length/payload/checksum byte
// frame into 32-bit words and holds the CPU in reset until the image verifies.
module instr_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
    chk_update = acc ^ data;
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [15:0] addr_r;
  logic [23:0] word_r;
  logic [1:0]  byte_idx_r;
  logic [7:0]  xor_r;
  logic [31:0] mem_waddr_r;
  logic [31:0] mem_wdata_r;
  logic        byte_ready_r;
  logic        mem_we_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;
  logic        xfer_s;
  logic [15:0] len_s;
  logic        len_bad_s;

  assign xfer_s    = byte_valid && byte_ready_r;
  assign len_s     = {byte_in, len_lo_r};
  assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > DEPTH_W);

  // Next-state decode for the framing FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_LEN_LO;
        else       next_state_s = ST_IDLE;
      end
      ST_LEN_LO: begin
        if (xfer_s) next_state_s = ST_LEN_HI;
        else        next_state_s = ST_LEN_LO;
      end
      ST_LEN_HI: begin
        if (xfer_s && len_bad_s) next_state_s = ST_ERROR;
        else if (xfer_s)         next_state_s = ST_DATA;
        else                     next_state_s = ST_LEN_HI;
      end
      ST_DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3)) next_state_s = ST_WRITE;
        else                                next_state_s = ST_DATA;
      end
      ST_WRITE: begin
        if ((addr_r + 16'd1) == len_r) next_state_s = ST_CHECK;
        else                           next_state_s = ST_DATA;
      end
      ST_CHECK: begin
        if (xfer_s && (byte_in == xor_r)) next_state_s = ST_DONE;
        else if (xfer_s)                  next_state_s = ST_ERROR;
        else                              next_state_s = ST_CHECK;
      end
      ST_DONE, ST_ERROR: begin
        if (start) next_state_s = ST_LEN_LO;
        else       next_state_s = state_r;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Length capture, word packing, checksum accumulation and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_r    <= 8'd0;
      len_r       <= 16'd0;
      addr_r      <= 16'd0;
      word_r      <= 24'd0;
      byte_idx_r  <= 2'd0;
      xor_r       <= 8'd0;
      mem_waddr_r <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_LEN_LO: begin
          if (xfer_s) len_lo_r <= byte_in;
        end
        ST_LEN_HI: begin
          if (xfer_s) begin
            len_r      <= len_s;
            addr_r     <= 16'd0;
            xor_r      <= 8'd0;
            byte_idx_r <= 2'd0;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            xor_r      <= chk_update(xor_r, byte_in);
            byte_idx_r <= byte_idx_r + 2'd1;
            word_r     <= {word_r[15:0], byte_in};
            // Address/data only move on the 4th byte so they stay stable between writes.
            if (byte_idx_r == 2'd3) begin
              mem_wdata_r <= {word_r, byte_in};
              mem_waddr_r <= {16'd0, addr_r};
            end
          end
        end
        ST_WRITE: addr_r <= addr_r + 16'd1;
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      byte_ready_r <= (next_state_s == ST_LEN_LO) || (next_state_s == ST_LEN_HI) ||
                      (next_state_s == ST_DATA)   || (next_state_s == ST_CHECK);
      mem_we_r     <= (next_state_s == ST_WRITE);
      cpu_hold_r   <= (next_state_s != ST_DONE);
      done_r       <= (next_state_s == ST_DONE);
      error_r      <= (next_state_s == ST_ERROR);
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued as
// frames are sent and retired as the DUT pulses mem_we.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[0:1023];

  instr_loader #(.DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // One clock; any write seen just after the edge is retired against the scoreboard.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write_word: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_waddr, mem_wdata, e[63:32], e[31:0]);
        end
      end
      vectors++;
      if (byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write: got byte_ready=%b, expected 0", byte_ready);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   waited;
    logic acc;
    byte_in = b;
    byte_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      acc = (byte_ready === 1'b1);
      step();
      waited++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_frame(input int n, input logic [7:0] chk_mask, input bit gappy,
                            input bit start_mid, input bit do_start);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    logic [15:0] nn;
    x = 8'd0;
    nn = n[15:0];
    for (int i = 0; i < n; i++) exp_q.push_back({i[31:0], img[i]});
    if (do_start) pulse_start();
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31-8*j -: 8];
        x = x ^ b;
        if (gappy && ($urandom_range(0, 1) == 1)) step();
        if (start_mid && i == 0 && j == 1) start = 1'b1;
        send_byte(b);
        start = 1'b0;
      end
    end
    send_byte(x ^ chk_mask);
  endtask

  task automatic check_final(input string name, input logic exp_done, input logic exp_err);
    vectors++;
    if ({done, error, cpu_hold} !== {exp_done, exp_err, ~exp_done} || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got done=%b error=%b cpu_hold=%b pending=%0d, expected %b %b %b 0",
               name, done, error, cpu_hold, exp_q.size(), exp_done, exp_err, ~exp_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if ({byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, error} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b",
               byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, error);
    end
    rst_n = 1'b1;
    step();
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    for (int i = 0; i < 4; i++) step();
    byte_valid = 1'b0;
    vectors++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_accept: got ready=%b hold=%b done=%b, expected 0 1 0", byte_ready, cpu_hold, done);
    end
  endtask

  task automatic test_nominal();
    img[0] = 32'h20080005;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h55;
    step();
    start = 1'b0;
    byte_valid = 1'b0;
    vectors++;
    if (byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_with_byte: got byte_ready=%b, expected 1 in LEN_LO", byte_ready);
    end
    load_frame(1, 8'h00, 1'b0, 1'b0, 1'b0);
    check_final("nominal", 1'b1, 1'b0);
  endtask

  task automatic test_multi_word();
    img[0] = 32'h00000001;
    img[1] = 32'h00000002;
    img[2] = 32'h00000003;
    load_frame(3, 8'h00, 1'b1, 1'b0, 1'b1);
    check_final("multi_word", 1'b1, 1'b0);
  endtask

  task automatic test_bad_checksum();
    img[0] = 32'h20080005;
    load_frame(1, 8'h09, 1'b0, 1'b0, 1'b1);
    check_final("bad_checksum", 1'b0, 1'b1);
    vectors++;
    if (byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL error_ready: got byte_ready=%b, expected 0", byte_ready);
    end
    load_frame(1, 8'h00, 1'b0, 1'b0, 1'b1);
    check_final("recover_after_error", 1'b1, 1'b0);
  endtask

  task automatic test_len_bounds();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check_final("len_zero", 1'b0, 1'b1);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    check_final("len_1025", 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    load_frame(1024, 8'h00, 1'b0, 1'b0, 1'b1);
    check_final("len_1024", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] w;
    img[0] = 32'hA1B2C3D4;
    img[1] = 32'h0F1E2D3C;
    exp_q.push_back({32'd0, img[0]});
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    w = img[0];
    for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
    w = img[1];
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, error} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}
        || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL async_reset: got ready=%b we=%b addr=%h data=%h hold=%b pending=%0d",
               byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, exp_q.size());
    end
    step();
    rst_n = 1'b1;
    step();
    load_frame(2, 8'h00, 1'b0, 1'b0, 1'b1);
    check_final("reload_after_reset", 1'b1, 1'b0);
  endtask

  task automatic test_robustness();
    byte_valid = 1'b1;
    byte_in = 8'h3C;
    for (int i = 0; i < 4; i++) step();
    byte_valid = 1'b0;
    vectors++;
    if (byte_ready !== 1'b0 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL done_no_accept: got ready=%b done=%b hold=%b, expected 0 1 0", byte_ready, done, cpu_hold);
    end
    pulse_start();
    vectors++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_hold: got hold=%b done=%b ready=%b, expected 1 0 1", cpu_hold, done, byte_ready);
    end
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h12345678;
    img[2] = 32'hCAFEF00D;
    load_frame(3, 8'h00, 1'b1, 1'b1, 1'b0);
    check_final("start_during_data", 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_multi_word();
    test_bad_checksum();
    test_len_bounds();
    test_reset_mid_data();
    test_robustness();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
